// File: rtl/izn_pkg.sv
// izn_pkg: definitions shared by the neuron core and the spike-synapse
// integrator. Provides the Q(1024) fixed-point scaling, the population size,
// the signed current type and the integrator FSM state encoding.
package izn_pkg;

  localparam int unsigned FRAC_BITS = 10;   // 1.0 == 1 << FRAC_BITS == 1024
  localparam int unsigned N_NEURONS = 128;

  typedef logic signed [31:0] q_current_t;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    UPDATE
  } syn_state_t;

endpackage

// File: rtl/spike_synapse_integrator_if.sv
// spike_synapse_integrator_if: bundle between the spike-frame producer and
// the synapse integrator.
//   population  producer -> integrator  N_SYN-bit spike frame
//   pop_valid   producer -> integrator  one-cycle frame strobe
//   syn_clear   producer -> integrator  synchronous clear of current/overrun
//   I_out       integrator -> producer  signed Q(1024) synaptic current
//   out_valid   integrator -> producer  one-cycle "I_out just updated"
//   busy        integrator -> producer  frame in progress
//   overrun     integrator -> producer  sticky dropped-frame flag
//   sat_flag    integrator -> producer  sticky clamp flag (SYN_SATURATE_EN only)
interface spike_synapse_integrator_if
  import izn_pkg::*;
#(
  parameter int unsigned N_SYN = N_NEURONS
);
  logic [N_SYN-1:0] population;
  logic             pop_valid;
  logic             syn_clear;
  q_current_t       I_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;
`ifdef SYN_SATURATE_EN
  logic             sat_flag;
`endif

  modport master (
    output population, pop_valid, syn_clear,
`ifdef SYN_SATURATE_EN
    input  sat_flag,
`endif
    input  I_out, out_valid, busy, overrun
  );

  modport slave (
    input  population, pop_valid, syn_clear,
`ifdef SYN_SATURATE_EN
    output sat_flag,
`endif
    output I_out, out_valid, busy, overrun
  );

endinterface

// File: rtl/pop_count.sv
// pop_count: combinational population count of a W-bit slice.
//   i_bits   in   W               bits to count
//   o_count  out  $clog2(W+1)     number of ones in i_bits
module pop_count #(
  parameter int unsigned W = 8
)(
  input  logic [W-1:0]           i_bits,
  output logic [$clog2(W+1)-1:0] o_count
);
  localparam int unsigned CW = $clog2(W+1);

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < W; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/spike_synapse_integrator.sv
// spike_synapse_integrator: converts each population spike frame into one
// signed Q(1024) synaptic current. A frame is popcounted BITS_PER_CYCLE bits
// per clock, then the running current is decayed by I >>> TAU_SHIFT and
// incremented by count*WEIGHT.
//   clk        in   rising-edge clock
//   reset_bar  in   asynchronous active-low reset
//   bus        slave modport of spike_synapse_integrator_if (frame in,
//              current/status out)
// Optional build macro SYN_SATURATE_EN: clamp the update to [-I_MAX, +I_MAX]
// and expose the sticky sat_flag; otherwise the sum wraps to 32 bits.
module spike_synapse_integrator
  import izn_pkg::*;
#(
  parameter int unsigned        N_SYN          = N_NEURONS,
  parameter int unsigned        BITS_PER_CYCLE = 8,
  parameter logic signed [31:0] WEIGHT         = 32'sd1024,
  parameter int unsigned        TAU_SHIFT      = 4,
  parameter logic signed [31:0] I_MAX          = 32'sd102400
)(
  input logic                       clk,
  input logic                       reset_bar,
  spike_synapse_integrator_if.slave bus
);
  localparam int unsigned BEATS  = N_SYN / BITS_PER_CYCLE;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W  = $clog2(N_SYN + 1);
  localparam int unsigned PC_W   = $clog2(BITS_PER_CYCLE + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  syn_state_t       r_state;
  logic [N_SYN-1:0] r_shift;
  logic [BEAT_W-1:0] r_beat;
  logic [CNT_W-1:0] r_count;
  q_current_t       r_I;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_overrun;

  logic [PC_W-1:0]   w_pc;
  q_current_t        w_decay;
  logic signed [40:0] w_prod;
  logic signed [41:0] w_sum;
  q_current_t        w_next;
  logic              w_clamp;

  pop_count #(.W(BITS_PER_CYCLE)) u_pop_count (
    .i_bits  (r_shift[BITS_PER_CYCLE-1:0]),
    .o_count (w_pc)
  );

  // Arithmetic shift floors toward -inf: small positive currents stick,
  // -1 decays to 0.
  assign w_decay = r_I >>> TAU_SHIFT;
  assign w_prod  = $signed({{(41-CNT_W){1'b0}}, r_count})
                 * $signed({{9{WEIGHT[31]}}, WEIGHT});
  assign w_sum   = $signed({{10{r_I[31]}}, r_I})
                 - $signed({{10{w_decay[31]}}, w_decay})
                 + $signed({w_prod[40], w_prod});

`ifdef SYN_SATURATE_EN
  localparam logic signed [41:0] LIM = {{10{I_MAX[31]}}, I_MAX};
  logic r_sat;

  always_comb begin
    w_clamp = 1'b0;
    w_next  = w_sum[31:0];
    if (w_sum > LIM) begin
      w_clamp = 1'b1;
      w_next  = I_MAX;
    end else if (w_sum < -LIM) begin
      w_clamp = 1'b1;
      w_next  = -I_MAX;
    end
  end

  assign bus.sat_flag = r_sat;
`else
  assign w_clamp = 1'b0;
  assign w_next  = w_sum[31:0];
`endif

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_beat      <= '0;
      r_count     <= '0;
      r_I         <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SYN_SATURATE_EN
      r_sat       <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      if (bus.syn_clear) begin
        // Clear beats everything, including a completing UPDATE.
        r_state   <= IDLE;
        r_beat    <= '0;
        r_count   <= '0;
        r_I       <= '0;
        r_busy    <= 1'b0;
        r_overrun <= 1'b0;
`ifdef SYN_SATURATE_EN
        r_sat     <= 1'b0;
`endif
      end else begin
        // UPDATE is still busy: a frame landing on it is an overrun too.
        if (bus.pop_valid && (r_state != IDLE)) begin
          r_overrun <= 1'b1;
        end
        case (r_state)
          IDLE: begin
            if (bus.pop_valid) begin
              r_shift <= bus.population;
              r_count <= '0;
              r_beat  <= '0;
              r_busy  <= 1'b1;
              r_state <= COUNT;
            end
          end
          COUNT: begin
            r_count <= r_count + CNT_W'(w_pc);
            r_shift <= r_shift >> BITS_PER_CYCLE;
            r_beat  <= r_beat + BEAT_W'(1);
            if (r_beat == LAST_BEAT) begin
              r_state <= UPDATE;
            end
          end
          UPDATE: begin
            r_I         <= w_next;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
`ifdef SYN_SATURATE_EN
            if (w_clamp) begin
              r_sat <= 1'b1;
            end
`endif
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.I_out     = r_I;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_spike_synapse_integrator.sv
module tb_spike_synapse_integrator;
  import izn_pkg::*;

  logic clk = 1'b0;
  logic reset_bar;
  always #5 clk = ~clk;

  spike_synapse_integrator_if #(.N_SYN(128)) bus ();
  spike_synapse_integrator_if #(.N_SYN(128)) bus_w ();

  spike_synapse_integrator dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .bus       (bus)
  );

  spike_synapse_integrator #(.WEIGHT(32'sd4096)) dut_w (
    .clk       (clk),
    .reset_bar (reset_bar),
    .bus       (bus_w)
  );

  int checks   = 0;
  int failures = 0;
  int q0[$];
  int qw[$];
  int e0, ew;

  logic [127:0] zeros = '0;
  logic [127:0] ones  = '1;
  logic [127:0] b5    = 128'd1 << 5;
  logic [127:0] b0    = 128'd1;
  logic [127:0] pat3  = {1'b1, 125'd0, 2'b11};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every out_valid must match the next queued value.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (q0.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("I_out", bus.I_out, e0);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_w.out_valid) begin
      if (qw.size() == 0) chk("unexpected_out_valid_w", 1, 0);
      else begin
        ew = qw.pop_front();
        chk("I_out_w", bus_w.I_out, ew);
      end
    end
  end

  // Called on a negedge; returns on the negedge after the sampling edge.
  task automatic issue(input bit w, input logic [127:0] p, input int exp, input bit push);
    if (!w) begin
      bus.population = p;
      bus.pop_valid  = 1'b1;
      if (push) q0.push_back(exp);
    end else begin
      bus_w.population = p;
      bus_w.pop_valid  = 1'b1;
      if (push) qw.push_back(exp);
    end
    @(negedge clk);
    bus.pop_valid   = 1'b0;
    bus_w.pop_valid = 1'b0;
  endtask

  task automatic frame(input bit w, input logic [127:0] p, input int exp);
    issue(w, p, exp, 1'b1);
    repeat (17) @(negedge clk);
  endtask

  task automatic clear();
    bus.syn_clear = 1'b1;
    @(negedge clk);
    bus.syn_clear = 1'b0;
    chk("clear_I_out", bus.I_out, 0);
    chk("clear_overrun", bus.overrun, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.population = '0;   bus.pop_valid = 1'b0;   bus.syn_clear = 1'b0;
    bus_w.population = '0; bus_w.pop_valid = 1'b0; bus_w.syn_clear = 1'b0;
    reset_bar = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_I_out", bus.I_out, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    reset_bar = 1'b1;
    @(negedge clk);

    // Empty frame: busy for 17 cycles, out_valid on the 18th.
    issue(1'b0, zeros, 0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      chk("lat_busy", bus.busy, 1);
      chk("lat_no_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    chk("lat_out_valid", bus.out_valid, 1);
    chk("lat_busy_done", bus.busy, 0);

    // Single spike then decay.
    frame(1'b0, b5, 1024);
    frame(1'b0, zeros, 960);
    frame(1'b0, zeros, 900);

    // Full frame from zero.
    clear();
    frame(1'b0, ones, 131072);
    chk("full_no_overrun", bus.overrun, 0);

    // Frame re-pulsed mid-COUNT is dropped.
    clear();
    issue(1'b0, pat3, 3072, 1'b1);
    repeat (4) @(negedge clk);
    bus.population = ones;
    bus.pop_valid  = 1'b1;
    @(negedge clk);
    bus.pop_valid  = 1'b0;
    repeat (12) @(negedge clk);
    chk("drop_overrun", bus.overrun, 1);
    chk("drop_busy", bus.busy, 0);
    clear();

    // pop_valid on the UPDATE edge is an overrun.
    issue(1'b0, b0, 1024, 1'b1);
    repeat (16) @(negedge clk);
    bus.population = ones;
    bus.pop_valid  = 1'b1;
    @(negedge clk);
    bus.pop_valid  = 1'b0;
    chk("upd_overrun", bus.overrun, 1);
    repeat (20) @(negedge clk);
    chk("upd_not_started", bus.busy, 0);
    chk("upd_overrun_sticky", bus.overrun, 1);
    clear();

    // syn_clear aborts an in-flight frame.
    frame(1'b0, b0, 1024);
    issue(1'b0, ones, 0, 1'b0);
    repeat (4) @(negedge clk);
    bus.syn_clear = 1'b1;
    @(negedge clk);
    bus.syn_clear = 1'b0;
    chk("abort_I_out", bus.I_out, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (20) @(negedge clk);
    chk("abort_idle", bus.busy, 0);

    // Reset during COUNT.
    frame(1'b0, b5, 1024);
    issue(1'b0, ones, 0, 1'b0);
    repeat (7) @(negedge clk);
    #1 reset_bar = 1'b0;
    #1;
    chk("midrst_I_out", bus.I_out, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    reset_bar = 1'b1;
    @(negedge clk);
    frame(1'b0, b5, 1024);

    // WEIGHT=4096, two full frames back-to-back.
`ifdef SYN_SATURATE_EN
    frame(1'b1, ones, 102400);
    frame(1'b1, ones, 102400);
    chk("sat_flag", bus_w.sat_flag, 1);
`else
    frame(1'b1, ones, 524288);
    frame(1'b1, ones, 1015808);
`endif
    chk("w_no_overrun", bus_w.overrun, 0);

    repeat (5) @(negedge clk);
    chk("queue_drained", q0.size(), 0);
    chk("queue_w_drained", qw.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
